// File: rtl/std_types.sv
// Shared scalar types and lane helpers for byte/word datapaths.
package std_types;

   localparam int unsigned U8  = 8;
   localparam int unsigned U4  = 4;
   localparam int unsigned U32 = 32;

   typedef logic [U8-1:0]  u8;
   typedef logic [U4-1:0]  u4;
   typedef logic [U32-1:0] u32;
   typedef logic           bool;

   localparam int unsigned U8_PER_U32 = U32 / U8;

   typedef logic [$clog2(U8_PER_U32)-1:0] lane_idx;

   // Contiguous lane mask for a word holding nbytes bytes from lane 0 upward.
   function automatic u4 lane_mask(input logic [2:0] nbytes);
      u4 m;
      case (nbytes)
         3'd1:    m = 4'h1;
         3'd2:    m = 4'h3;
         3'd3:    m = 4'h7;
         3'd4:    m = 4'hF;
         default: m = 4'h0;
      endcase
      return m;
   endfunction

   function automatic u32 swap_bytes(input u32 w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic u4 swap_lanes(input u4 k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

endpackage

// File: rtl/u8_to_u32_packer.sv
// Byte-stream to 32-bit word gearbox with packet-end and idle-timeout flush.
module u8_to_u32_packer
   import std_types::*;
#(
   parameter bit          BIG_ENDIAN    = 1'b0,
   parameter int unsigned FLUSH_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  bool  in_valid,
   output bool  in_ready,
   input  u8    in_data,
   input  bool  in_last,
   output bool  out_valid,
   input  bool  out_ready,
   output u32   out_data,
   output u4    out_keep,
   output bool  out_last,
   output bool  out_flush
);

   lane_idx    cnt_q;
   u32         acc_q;
   u32         acc_new;
   u32         load_data;
   u4          load_keep;
   logic [2:0] nbytes;
   bool        accept;
   bool        complete;
   bool        timeout_hit;
   bool        do_flush;
   bool        load;

   always_comb begin
      in_ready  = !out_valid || out_ready;
      accept    = in_valid && in_ready;
      acc_new   = acc_q | (u32'(in_data) << {cnt_q, 3'b000});
      complete  = accept && ((cnt_q == 2'd3) || in_last);
      // A byte arriving in the same cycle always wins over a pending flush.
      do_flush  = timeout_hit && in_ready && !accept;
      load      = complete || do_flush;
      nbytes    = {1'b0, cnt_q} + (complete ? 3'd1 : 3'd0);
      load_data = complete ? acc_new : acc_q;
      load_keep = lane_mask(nbytes);
      if (BIG_ENDIAN) begin
         load_data = swap_bytes(load_data);
         load_keep = swap_lanes(load_keep);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + 2'd1;
         acc_q <= acc_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_flush <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_keep  <= load_keep;
         out_last  <= complete && in_last;
         out_flush <= do_flush;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   if (FLUSH_TIMEOUT > 0) begin : gen_timeout
      localparam logic [15:0] Limit = 16'(FLUSH_TIMEOUT);
      logic [15:0] idle_q;

      // Saturates at Limit so a blocked flush stays armed until the register frees.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            idle_q <= '0;
         end else if (accept || (cnt_q == '0) || load) begin
            idle_q <= '0;
         end else if (idle_q != Limit) begin
            idle_q <= idle_q + 16'd1;
         end
      end

      assign timeout_hit = (cnt_q != '0) && (idle_q == Limit);
   end else begin : gen_no_timeout
      assign timeout_hit = 1'b0;
   end

endmodule
